// File: rtl/vx_lane_serializer_if.sv
// Handshake bundle between dispatch (in_*) and a narrow execute unit (out_*).
// master drives packets in and consumes batches; slave is the serializer side.
interface vx_lane_serializer_if #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_WIDTH   = 64
);
  localparam int BATCHES   = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH = (BATCHES > 1) ? $clog2(BATCHES) : 1;

  logic                        in_valid;
  logic [HDR_WIDTH-1:0]        in_header;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [NUM_THREADS*XLEN-1:0] in_rs1_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs2_data;
  logic [NUM_THREADS*XLEN-1:0] in_rs3_data;
  logic                        in_ready;

  logic                        out_valid;
  logic [HDR_WIDTH-1:0]        out_header;
  logic [NUM_LANES-1:0]        out_tmask;
  logic [NUM_LANES*XLEN-1:0]   out_rs1_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs2_data;
  logic [NUM_LANES*XLEN-1:0]   out_rs3_data;
  logic [PID_WIDTH-1:0]        out_pid;
  logic                        out_sop;
  logic                        out_eop;
  logic                        out_ready;

  modport master (
    output in_valid, in_header, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    input  in_ready, out_valid, out_header, out_tmask, out_rs1_data, out_rs2_data,
           out_rs3_data, out_pid, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_header, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
    output in_ready, out_valid, out_header, out_tmask, out_rs1_data, out_rs2_data,
           out_rs3_data, out_pid, out_sop, out_eop
  );
endinterface

// File: rtl/vx_lane_serializer.sv
// Splits one full-warp operand packet into NUM_LANES-wide batches, skipping
// batches whose mask slice is empty.
//   state  | meaning
//   S_IDLE | holding register empty, ready for a packet
//   S_BUSY | emitting batches of the held packet, lowest remaining pid first
module vx_lane_serializer #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_WIDTH   = 64
) (
  input logic                clk,
  input logic                reset,
  vx_lane_serializer_if.slave bus
);
  localparam int BATCHES   = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int SLICE_W   = NUM_LANES * XLEN;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                      state_q, state_d;
  logic [HDR_WIDTH-1:0]        hdr_q, hdr_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs1_d;
  logic [NUM_THREADS*XLEN-1:0] rs2_q, rs2_d;
  logic [NUM_THREADS*XLEN-1:0] rs3_q, rs3_d;
  logic [BATCHES-1:0]          rem_q, rem_d;
  logic                        first_q, first_d;

  logic [BATCHES-1:0]   rem_load;
  logic [PID_WIDTH-1:0] pid;
  logic [31:0]          sel;
  logic                 eop;
  logic                 fire;
  logic                 accept;

  always_comb begin
    pid = '0;
    for (int b = BATCHES - 1; b >= 0; b--) begin
      if (rem_q[b]) pid = PID_WIDTH'(b);
    end
  end

  assign sel    = 32'(pid);
  assign eop    = (rem_q != '0) && ((rem_q & (rem_q - 1'b1)) == '0);
  assign fire   = (state_q == S_BUSY) && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  // An all-zero mask still emits batch 0 so the instruction is not lost.
  always_comb begin
    rem_load = '0;
    for (int b = 0; b < BATCHES; b++) begin
      rem_load[b] = |bus.in_tmask[b*NUM_LANES +: NUM_LANES];
    end
    if (rem_load == '0) rem_load[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tmask_d = tmask_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    rem_d   = rem_q;
    first_d = first_q;
    if (fire) begin
      if (eop) begin
        state_d = S_IDLE;
        rem_d   = '0;
        first_d = 1'b1;
      end else begin
        rem_d[pid] = 1'b0;
        first_d    = 1'b0;
      end
    end
    if (accept) begin
      state_d = S_BUSY;
      hdr_d   = bus.in_header;
      tmask_d = bus.in_tmask;
      rs1_d   = bus.in_rs1_data;
      rs2_d   = bus.in_rs2_data;
      rs3_d   = bus.in_rs3_data;
      rem_d   = rem_load;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      tmask_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tmask_q <= tmask_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE) || (fire && eop);
  assign bus.out_valid    = (state_q == S_BUSY);
  assign bus.out_header   = hdr_q;
  assign bus.out_pid      = pid;
  assign bus.out_sop      = first_q;
  assign bus.out_eop      = eop;
  assign bus.out_tmask    = tmask_q[sel*NUM_LANES +: NUM_LANES];
  assign bus.out_rs1_data = rs1_q[sel*SLICE_W +: SLICE_W];
  assign bus.out_rs2_data = rs2_q[sel*SLICE_W +: SLICE_W];
  assign bus.out_rs3_data = rs3_q[sel*SLICE_W +: SLICE_W];
endmodule
